shift_unpack: RTL and testbench

SHIFT_UNPACK -- requirements
Module: shift_unpack

---
 rtl/shift_pkg.sv | 13 +
 rtl/unpack_stage.sv | 29 ++
 rtl/shift_unpack.sv | 112 +++++++++++
 tb/tb_shift_unpack.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift-chain unpacker: FSM state encoding
// and the default word geometry used by the top and its stages.
package shift_pkg;

    localparam int DEFAULT_WIDTH = 3;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/unpack_stage.sv
// One WIDTH-bit link of the unpacking shift chain. A load captures this
// stage's slice of the packed input; a shift takes the word from the
// next-lower stage, so the chain moves data toward the MSB end.
module unpack_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    input  logic [WIDTH-1:0] shift_data,
    output logic [WIDTH-1:0] q
);

    // Load has priority over shift; the controller never asserts both at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= shift_data;
        end
    end

endmodule

// File: rtl/shift_unpack.sv
// Reader for a shift-chain packer: takes a DEPTH-word packed input and
// emits its words one per cycle, highest-index (oldest) word first and
// word 0 last, with out_last marking word 0. A new packet can be loaded
// on the same cycle the last word leaves, so back-to-back packets stream
// without a bubble.
module shift_unpack
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*DEPTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last
);

    localparam int CNT_W = $clog2(DEPTH);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             in_xfer;
    logic             out_xfer;
    logic             load;
    logic             shift;
    logic [WIDTH-1:0] stage_q  [DEPTH];
    logic [WIDTH-1:0] shift_in [DEPTH];

    // Handshake decode. out_valid comes purely from state so it never
    // depends on out_ready; in_ready opens early while the last word is
    // being accepted to allow a zero-bubble reload.
    assign out_valid = (state == SHIFT);
    assign out_last  = out_valid && (count == '0);
    assign in_ready  = (state == IDLE) || (out_last && out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign load      = in_xfer;
    assign shift     = out_xfer && !out_last;
    assign out_data  = stage_q[DEPTH-1];

    // Stage k holds word k after a load and is fed by stage k-1 on a
    // shift; the bottom stage fills with zeros.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_bottom
            assign shift_in[k] = '0;
        end else begin : g_link
            assign shift_in[k] = stage_q[k-1];
        end

        unpack_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .shift      (shift),
            .load_data  (in_data[k*WIDTH +: WIDTH]),
            .shift_data (shift_in[k]),
            .q          (stage_q[k])
        );
    end

    // State register; reset wins over any same-cycle transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: enter SHIFT on a load, leave only after word 0 is taken
    // with no replacement packet arriving on that same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_xfer) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (out_xfer && out_last) begin
                    state_next = in_xfer ? SHIFT : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Remaining-word counter: reloaded with each packet and stepped down
    // per accepted word; it cannot step below zero because word 0 is
    // handled by the last-word path instead of a shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(DEPTH - 1);
        end else if (shift) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_shift_unpack.sv
// Self-checking bench for shift_unpack (WIDTH=3, DEPTH=4). Every accepted
// packet is split into its expected word stream and queued; each cycle the
// DUT's handshake and output word are compared against the queue head.
module tb_shift_unpack;

    localparam int WIDTH = 3;
    localparam int DEPTH = 4;
    localparam int PW    = WIDTH * DEPTH;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [WIDTH-1:0] out_data;
    logic          out_last;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    shift_unpack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then check the DUT
    // against the scoreboard and update it for any transfers on this cycle.
    task automatic applyStimulus(input logic iv, input logic [PW-1:0] id,
                                 input logic ordy, input logic r,
                                 output logic accepted);
        logic [PW-1:0] pkt;
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        accepted = 1'b0;
        if (r) begin
            sb.delete();
        end else begin
            checkOutput("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            checkOutput("in_ready", 32'(in_ready),
                        32'((sb.size() == 0) || (sb.size() == 1 && ordy)));
            if (out_valid && sb.size() != 0) begin
                checkOutput("out_data", 32'(out_data), 32'(sb[0].data));
                checkOutput("out_last", 32'(out_last), 32'(sb[0].last));
                if (ordy) begin
                    void'(sb.pop_front());
                end
            end
            if (iv && in_ready) begin
                accepted = 1'b1;
                pkt = id;
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    exp_t e;
                    e.data = pkt[k*WIDTH +: WIDTH];
                    e.last = (k == 0);
                    sb.push_back(e);
                end
            end
        end
    endtask

    initial begin
        logic acc;
        int   sent;
        int   cyc;
        logic [PW-1:0] pkt;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;

        // Reset, then confirm the idle outputs.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, acc);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, acc);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);

        // Single packet: 7,6,5,4 with last on 4.
        applyStimulus(1'b1, 12'hFAC, 1'b1, 1'b0, acc);
        checkOutput("single_accept", 32'(acc), 32'd1);
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);

        // Back-to-back: second packet accepted on the first packet's last word.
        applyStimulus(1'b1, 12'hFAC, 1'b1, 1'b0, acc);
        cyc = 0;
        do begin
            applyStimulus(1'b1, 12'h053, 1'b1, 1'b0, acc);
            cyc++;
        end while (!acc && cyc < 10);
        checkOutput("b2b_accept_cycle", 32'(cyc), 32'(DEPTH));
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);

        // Backpressure: hold the first word for two cycles.
        applyStimulus(1'b1, 12'hFAC, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);

        // Reset after word 6, then a fresh packet.
        applyStimulus(1'b1, 12'hFAC, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 12'h053, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
        checkOutput("post_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("post_rst_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 12'h053, 1'b1, 1'b0, acc);
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);

        // Random valid/ready: a packet stays offered until it is accepted.
        sent = 0;
        cyc  = 0;
        pkt  = PW'($urandom);
        while (sent < 1000 && cyc < 30000) begin
            applyStimulus(1'($urandom_range(0, 1)), pkt, 1'($urandom_range(0, 1)), 1'b0, acc);
            if (acc) begin
                sent++;
                pkt = PW'($urandom);
            end
            cyc++;
        end
        checkOutput("random_sent", 32'(sent), 32'd1000);

        // Drain whatever is still queued.
        cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
            cyc++;
        end
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
